// File: rtl/part1_pkg.sv
// Shared constants for the part1 array multiplier.
// latency() reports the P pipeline depth, which grows with PART1_INPUT_REG_EN.
package part1_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned PROD_W    = 2 * WIDTH_DEF;

    function automatic int unsigned latency();
`ifdef PART1_INPUT_REG_EN
        return 2;
`else
        return 1;
`endif
    endfunction

endpackage

// File: rtl/part1_fa.sv
// 1-bit full adder cell used throughout the multiplier array.
// Half-adder positions tie cin to 0.
module part1_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/part1.sv
// Unsigned WIDTH x WIDTH carry-save array multiplier with a registered product.
// Define PART1_INPUT_REG_EN to register A/B first (latency 2 instead of 1).
module part1
    import part1_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

`ifdef PART1_INPUT_REG_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = A;
    assign op_b = B;
`endif

    logic [WIDTH-1:0]   pp    [WIDTH];
    logic [WIDTH-1:0]   s_row [WIDTH];
    logic [WIDTH-1:0]   c_row [WIDTH];
    logic [WIDTH-1:0]   rc;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pp_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_pp_col
            assign pp[i][j] = op_a[j] & op_b[i];
        end
    end

    // Row 0 is the bare partial product; its carry vector is empty, so row 1 acts as half adders.
    assign s_row[0] = pp[0];
    assign c_row[0] = '0;
    assign prod[0]  = s_row[0][0];

    // Cell (i,j) sits at weight i+j: it adds pp[i][j], the previous row's sum one column up,
    // and the previous row's carry in the same column.
    for (genvar i = 1; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            logic s_in;
            if (j < WIDTH - 1) begin : g_sum_in
                assign s_in = s_row[i-1][j+1];
            end else begin : g_sum_top
                assign s_in = 1'b0;
            end

            part1_fa u_fa (
                .a    (pp[i][j]),
                .b    (s_in),
                .cin  (c_row[i-1][j]),
                .s    (s_row[i][j]),
                .cout (c_row[i][j])
            );
        end
        assign prod[i] = s_row[i][0];
    end

    // Ripple row merges the last sum/carry vectors into the upper WIDTH bits.
    assign rc[0] = 1'b0;
    for (genvar k = 0; k < WIDTH - 1; k++) begin : g_ripple
        part1_fa u_fa (
            .a    (s_row[WIDTH-1][k+1]),
            .b    (c_row[WIDTH-1][k]),
            .cin  (rc[k]),
            .s    (prod[WIDTH+k]),
            .cout (rc[k+1])
        );
    end

    // The product fits in 2*WIDTH bits, so the MSB cell never carries out.
    assign prod[2*WIDTH-1] = c_row[WIDTH-1][WIDTH-1] ^ rc[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= prod;
        end
    end

    assign P = p_q;

endmodule

// File: tb/tb_part1.sv
// Self-checking bench for part1: directed vector table, reset sequences and a full
// 65536-pair stream with a mid-stream reset; expected P is delayed by latency().
module tb_part1;
    import part1_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned lat;
    logic [15:0] prev_stage;

    part1 #(
        .WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        r;
        logic [15:0] prod;
        string       name;
    } vec_t;

    // Drive one cycle of inputs, clock, then compare P against the latency-aware model.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r,
                        input logic [15:0] prod, input string name);
        logic [15:0] cur;
        logic [15:0] expected;
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
        cur = r ? 16'h0000 : prod;
        if (lat == 1) expected = cur;
        else          expected = r ? 16'h0000 : prev_stage;
        prev_stage = cur;
        n_cmp++;
        if (P !== expected) begin
            n_bad++;
            $display("FAIL %s: A=%02h B=%02h rst=%0b P=%04h expected=%04h",
                     name, a, b, r, P, expected);
        end
    endtask

    vec_t vecs [21];

    initial begin
        lat        = latency();
        prev_stage = 16'h0000;
        n_cmp      = 0;
        n_bad      = 0;
        A          = 8'h00;
        B          = 8'h00;
        rst        = 1'b1;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b1, 16'h0000, "reset0"};
        vecs[1]  = '{8'hFF, 8'hFF, 1'b1, 16'h0000, "reset1"};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 16'h0000, "reset2"};
        vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "release_ff_ff"};
        vecs[4]  = '{8'h00, 8'hA5, 1'b0, 16'h0000, "zero_a"};
        vecs[5]  = '{8'h01, 8'hA5, 1'b0, 16'h00A5, "one_a"};
        vecs[6]  = '{8'h80, 8'h02, 1'b0, 16'h0100, "msb_times_2"};
        vecs[7]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF, "ff_times_1"};
        vecs[8]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "max_max"};
        vecs[9]  = '{8'h0F, 8'hF0, 1'b0, 16'h0E10, "nibbles"};
        vecs[10] = '{8'hAA, 8'h55, 1'b0, 16'h3872, "alt_bits"};
        vecs[11] = '{8'h12, 8'h34, 1'b0, 16'h03A8, "h12_h34"};
        vecs[12] = '{8'h80, 8'h80, 1'b0, 16'h4000, "msb_msb"};
        vecs[13] = '{8'h01, 8'h01, 1'b0, 16'h0001, "one_one"};
        vecs[14] = '{8'hA5, 8'h00, 1'b0, 16'h0000, "zero_b"};
        vecs[15] = '{8'h03, 8'h07, 1'b0, 16'h0015, "h03_h07"};
        vecs[16] = '{8'hC8, 8'h64, 1'b1, 16'h0000, "mid_reset"};
        vecs[17] = '{8'hC8, 8'h64, 1'b0, 16'h4E20, "after_reset"};
        vecs[18] = '{8'h7F, 8'h81, 1'b0, 16'h3FFF, "h7f_h81"};
        vecs[19] = '{8'hFE, 8'hFF, 1'b0, 16'hFD02, "hfe_hff"};
        vecs[20] = '{8'h10, 8'h10, 1'b0, 16'h0100, "h10_h10"};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].prod, vecs[i].name);
        end

        // Reset pulse between two changing products: only that edge is cleared.
        step(8'h11, 8'h11, 1'b0, 16'h0121, "pre_pulse");
        step(8'h22, 8'h22, 1'b1, 16'h0000, "pulse");
        step(8'h33, 8'h33, 1'b0, 16'h0A29, "post_pulse0");
        step(8'h44, 8'h44, 1'b0, 16'h1210, "post_pulse1");

        // Full operand sweep, back to back, with one reset edge in the middle.
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] idx;
            logic [7:0]  a;
            logic [7:0]  b;
            logic [15:0] prod;
            idx  = i[15:0];
            a    = idx[15:8];
            b    = idx[7:0];
            prod = {8'h00, a} * {8'h00, b};
            step(a, b, (i == 30000), prod, "stream");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
